// File: rtl/hex_display_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment display; nibbles are double-buffered
// so a frame never mixes old and new digits. Optional macro: LEADING_ZERO_BLANK_EN.
module hex_display_scan #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [3:0]            hex_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  dp_out,
    output logic                  frame
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRESCALE_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0][3:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
    logic                   pend_flag_q, pend_flag_d;
    logic [DIGITS-1:0][3:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
    logic [3:0]             hex_q, hex_d;
    logic [DIGITS-1:0]      digit_en_q, digit_en_d;
    logic                   dp_q, dp_d;
    logic                   frame_q, frame_d;

    logic                   tick;
    logic                   boundary;
    logic [DIGITS-1:0]      show;
    logic                   lit;

    assign tick     = (cnt_q == PRESCALE_W'(PRESCALE - 1));
    assign boundary = tick && (idx_q == IDX_W'(DIGITS - 1));

    // Digits allowed to light; leading-zero suppression looks only at disp so it
    // can change only at a frame boundary.
    always_comb begin
        show = '1;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic nz_above;
            nz_above = 1'b0;
            for (int k = DIGITS - 1; k > 0; k--) begin
                nz_above = nz_above | (disp_data_q[k] != 4'h0);
                show[k]  = nz_above;
            end
        end
`endif
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        frame_d     = 1'b0;

        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // The boundary consumes the old pending value; a load on the same edge
        // refills pend and keeps the flag set for the next boundary.
        if (boundary && pend_flag_q) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
            pend_flag_d = 1'b0;
            frame_d     = 1'b1;
        end
        if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_flag_d = 1'b1;
        end

        lit        = !blank && show[idx_q];
        hex_d      = disp_data_q[idx_q];
        digit_en_d = lit ? ~(DIGITS'(1) << idx_q) : '1;
        dp_d       = lit ? ~disp_dp_q[idx_q] : 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            hex_q       <= 4'h0;
            digit_en_q  <= '1;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_flag_q <= pend_flag_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            hex_q       <= hex_d;
            digit_en_q  <= digit_en_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign hex_out  = hex_q;
    assign digit_en = digit_en_q;
    assign dp_out   = dp_q;
    assign frame    = frame_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan (DIGITS=4, PRESCALE=4); per-cycle expectations are
// queued per frame and compared at the falling edge after each rising edge.
module tb_hex_display_scan;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [3:0]  hex_out;
    logic [3:0]  digit_en;
    logic        dp_out;
    logic        frame;

    hex_display_scan #(
        .DIGITS     (DIGITS),
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .load     (load),
        .blank    (blank),
        .hex_out  (hex_out),
        .digit_en (digit_en),
        .dp_out   (dp_out),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         fr;
        logic [9:0] vec;   // {hex_out, digit_en, dp_out, frame}
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    function automatic bit digit_shown(input logic [15:0] val, input int idx);
`ifdef LEADING_ZERO_BLANK_EN
        return (idx == 0) || ((val >> (4 * idx)) != 16'h0);
`else
        return 1'b1;
`endif
    endfunction

    // Queue the 16 cycles of frame f: outputs after rising edges 16f+1 .. 16f+16.
    task automatic push_frame(input int f, input logic [15:0] val, input logic [3:0] dp,
                              input logic pulse_next, input int blo, input int bhi);
        for (int j = 0; j < 16; j++) begin
            exp_t e;
            int   n;
            int   idx;
            bit   off;
            n     = 16 * f + 1 + j;
            idx   = j / 4;
            off   = (n >= blo && n <= bhi) || !digit_shown(val, idx);
            e.cyc = n;
            e.fr  = f;
            e.vec = {val[4*idx +: 4],
                     off ? 4'hF : ~(4'b0001 << idx),
                     off ? 1'b1 : ~dp[idx],
                     (j == 15) ? pulse_next : 1'b0};
            sb.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check($sformatf("frame%0d_cyc%0d", e.fr, e.cyc),
                  {hex_out, digit_en, dp_out, frame}, e.vec);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Load is sampled on rising edge n.
    task automatic do_load(input int n, input logic [15:0] d, input logic [3:0] dp);
        run_to(n - 1);
        data_in = d;
        dp_in   = dp;
        load    = 1'b1;
        run_to(n);
        load    = 1'b0;
    endtask

    initial begin
        // Power-on reset.
        #1 rst_n = 1'b0;
        #1 check("por", {hex_out, digit_en, dp_out, frame}, {4'h0, 4'b1111, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Fill the display, then drop reset asynchronously mid-scan.
        do_load(2, 16'hFFFF, 4'b0000);
        run_to(20);
        check("pre_reset", {hex_out, digit_en}, {4'hF, 4'b1110});
        #2 rst_n = 1'b0;
        #1 check("async_reset", {hex_out, digit_en, dp_out, frame}, {4'h0, 4'b1111, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Frame 0: cleared display, first tick 4 clks after release.
        push_frame(0, 16'h0000, 4'b0000, 1'b1, 0, -1);
        do_load(5, 16'h1234, 4'b0000);
        run_to(16);
        push_frame(1, 16'h1234, 4'b0000, 1'b1, 0, -1);

        // Load mid-frame must not tear the current frame.
        do_load(22, 16'hABCD, 4'b0000);
        run_to(32);
        push_frame(2, 16'hABCD, 4'b0000, 1'b1, 0, -1);

        // Load on the boundary edge lands one frame later.
        do_load(40, 16'h5555, 4'b0000);
        do_load(48, 16'h6666, 4'b0000);
        push_frame(3, 16'h5555, 4'b0000, 1'b1, 0, -1);
        run_to(64);
        push_frame(4, 16'h6666, 4'b0000, 1'b1, 0, -1);

        // Decimal point on digit 2, plus a 10-clk blank window.
        do_load(70, 16'h4321, 4'b0100);
        run_to(80);
        push_frame(5, 16'h4321, 4'b0100, 1'b0, 85, 94);
        run_to(84);
        blank = 1'b1;
        run_to(94);
        blank = 1'b0;
        run_to(96);
        push_frame(6, 16'h4321, 4'b0100, 1'b1, 0, -1);

        // Leading zeros.
        do_load(100, 16'h0050, 4'b0000);
        run_to(112);
        push_frame(7, 16'h0050, 4'b0000, 1'b1, 0, -1);
        do_load(116, 16'h0000, 4'b0000);
        run_to(128);
        push_frame(8, 16'h0000, 4'b0000, 1'b0, 0, -1);
        run_to(144);

        check("scoreboard_drained", 10'(sb.size()), 10'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
